// File: rtl/spi_reg_ctrl.sv
// SPI register controller: decodes SPI slave header/data handshakes into
// reads and writes of a small register file. The low registers are SPI-writable
// configuration. The top four are hardware-owned status, and the last of them
// collects sticky events that a SPI read clears.
module spi_reg_ctrl #(
    parameter int payload = 8,
    parameter int addrsz  = 7,
    parameter int nregs   = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [addrsz-1:0]         reg_addr,
    input  logic                      addr_dv,
    input  logic                      rw,
    input  logic [payload-1:0]        rx_d,
    input  logic                      rxdv,
    output logic [payload-1:0]        tx_d,
    output logic                      tx_en,
    input  logic                      hw_we,
    input  logic [1:0]                hw_addr,
    input  logic [payload-1:0]        hw_wdata,
    input  logic [payload-1:0]        hw_event,
    output logic [nregs*payload-1:0]  cfg,
    output logic                      cfg_wr,
    output logic [addrsz-1:0]         cfg_wr_addr,
    output logic [7:0]                err_cnt
);

    localparam int idxw      = (nregs > 1) ? $clog2(nregs) : 1;
    localparam int stat_base = nregs - 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DECODE    = 3'd1,
        RD_DRIVE  = 3'd2,
        WR_WAIT   = 3'd3,
        WR_COMMIT = 3'd4,
        DONE      = 3'd5
    } state_t;

    // Address lies inside the implemented register file.
    function automatic logic in_range(input logic [addrsz-1:0] a);
        return (32'(a) < 32'(nregs));
    endfunction

    // Address selects a SPI-writable configuration register.
    function automatic logic is_cfg_addr(input logic [addrsz-1:0] a);
        return (32'(a) < 32'(stat_base));
    endfunction

    state_t              state_r;
    state_t              state_s;
    logic [addrsz-1:0]   addr_r;
    logic                rw_r;
    logic                addr_dv_r;
    logic                rxdv_r;
    logic [payload-1:0]  regs_r [nregs];

    logic                start_s;
    logic [idxw-1:0]     idx_s;
    logic [payload-1:0]  rd_val_s;
    logic                rd_clear_s;
    logic                wr_commit_s;
    logic                err_inc_s;
    logic [payload-1:0]  evt_next_s;

    // addr_dv_r resets high so a transaction already in flight at reset release
    // is ignored until addr_dv has been seen low.
    assign start_s     = addr_dv && !addr_dv_r;
    assign idx_s       = addr_r[idxw-1:0];
    assign rd_clear_s  = (state_r == RD_DRIVE) && !addr_dv &&
                         (32'(addr_r) == 32'(nregs - 1));
    assign wr_commit_s = (state_r == WR_COMMIT) && is_cfg_addr(addr_r);
    assign err_inc_s   = ((state_r == DECODE) && rw_r && !in_range(addr_r)) ||
                         ((state_r == WR_COMMIT) && !is_cfg_addr(addr_r));

    // Read data mux: out-of-range addresses read as zero.
    always_comb begin
        rd_val_s = '0;
        if (in_range(addr_r)) begin
            rd_val_s = regs_r[idx_s];
        end else begin
            rd_val_s = '0;
        end
    end

    // Next value of the sticky event register: hw write or read-clear, then events OR-ed on top.
    always_comb begin
        evt_next_s = regs_r[nregs-1];
        if (hw_we && (hw_addr == 2'd3)) begin
            evt_next_s = hw_wdata;
        end else if (rd_clear_s) begin
            evt_next_s = '0;
        end else begin
            evt_next_s = regs_r[nregs-1];
        end
        evt_next_s = evt_next_s | hw_event;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) state_s = DECODE;
                else         state_s = IDLE;
            end
            DECODE: begin
                if (rw_r) state_s = RD_DRIVE;
                else      state_s = WR_WAIT;
            end
            RD_DRIVE: begin
                if (!addr_dv) state_s = IDLE;
                else          state_s = RD_DRIVE;
            end
            WR_WAIT: begin
                if (!addr_dv)              state_s = IDLE;
                else if (rxdv && !rxdv_r)  state_s = WR_COMMIT;
                else                       state_s = WR_WAIT;
            end
            WR_COMMIT: state_s = DONE;
            DONE: begin
                if (!addr_dv) state_s = IDLE;
                else          state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // Header capture and handshake edge history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_r    <= '0;
            rw_r      <= 1'b0;
            addr_dv_r <= 1'b1;
            rxdv_r    <= 1'b0;
        end else begin
            addr_dv_r <= addr_dv;
            rxdv_r    <= rxdv;
            if ((state_r == IDLE) && start_s) begin
                addr_r <= reg_addr;
                rw_r   <= rw;
            end
        end
    end

    // Register file: SPI config writes, hardware status writes, sticky events.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int n = 0; n < nregs; n++) begin
                regs_r[n] <= '0;
            end
        end else begin
            for (int n = 0; n < nregs; n++) begin
                if (n < stat_base) begin
                    if (wr_commit_s && (32'(idx_s) == 32'(n))) begin
                        regs_r[n] <= rx_d;
                    end
                end else if (n == nregs - 1) begin
                    regs_r[n] <= evt_next_s;
                end else if (hw_we && (32'(hw_addr) == 32'(n - stat_base))) begin
                    regs_r[n] <= hw_wdata;
                end
            end
        end
    end

    // Registered SPI-side outputs: read snapshot, write pulse, error counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_d        <= '0;
            tx_en       <= 1'b0;
            cfg_wr      <= 1'b0;
            cfg_wr_addr <= '0;
            err_cnt     <= 8'd0;
        end else begin
            tx_en  <= (state_s == RD_DRIVE);
            cfg_wr <= wr_commit_s;
            if ((state_r == DECODE) && rw_r) begin
                tx_d <= rd_val_s;
            end
            if (wr_commit_s) begin
                cfg_wr_addr <= addr_r;
            end
            if (err_inc_s && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    // Flattened register view, straight from storage.
    for (genvar g = 0; g < nregs; g++) begin : g_cfg
        assign cfg[g*payload +: payload] = regs_r[g];
    end

endmodule
